// File: rtl/bus_transfer_sequencer.sv
// Register-bus initiator: steps a writable microprogram, one enable/latch transfer per clock edge.
// Optional SEQ_ERR_CHECK_EN adds a sticky err flag for illegal or suspicious transfer words.
module bus_transfer_sequencer #(
  parameter int NUM_REGS   = 10,
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic                one_shot_clock,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       start_addr,
  input  logic                halt,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [8:0]          prog_wdata,
  output logic [NUM_REGS-1:0] enable,
  output logic [NUM_REGS-1:0] latch,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [3:0]          NREG     = 4'(NUM_REGS);
  localparam logic [AW-1:0]       PC_MAX   = AW'(PROG_DEPTH - 1);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [8:0]    mem_q [PROG_DEPTH];

  logic [8:0] word;
  logic       last;
  logic [3:0] src, dst;
  logic       src_ok, dst_ok;

  assign word   = mem_q[pc_q];
  assign last   = word[8];
  assign dst    = word[7:4];
  assign src    = word[3:0];
  assign src_ok = (src < NREG);
  assign dst_ok = (dst < NREG);

  assign pc   = pc_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    enable  = '0;
    latch   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = start_addr;
        end
      end
      S_RUN: begin
        if (!halt) begin
          if (src_ok) enable = ONE_HOT0 << src;
          if (dst_ok) latch  = ONE_HOT0 << dst;
          // The last physical word terminates the program; pc never wraps.
          if (last || pc_q == PC_MAX) state_d = S_DONE;
          else                        pc_d    = pc_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= 9'h1FF;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (prog_we && !busy) mem_q[prog_addr] <= prog_wdata;
    end
  end

`ifdef SEQ_ERR_CHECK_EN
  logic err_q;
  logic src_rsvd, dst_rsvd, bad_word;

  // Codes NUM_REGS..14 are reserved; 15 is the explicit "none" code.
  assign src_rsvd = !src_ok && (src != 4'hF);
  assign dst_rsvd = !dst_ok && (dst != 4'hF);
  assign bad_word = src_rsvd || dst_rsvd ||
                    (dst_ok && src == 4'hF) ||
                    (src_ok && src == dst);

  always_ff @(posedge one_shot_clock) begin
    if (reset)                                          err_q <= 1'b0;
    else if (state_q == S_RUN && !halt && bad_word)     err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
